// File: rtl/productor_serial_if.sv
// Operand/result handshake bundle for productor_serial.
// master = producer/consumer side, slave = the multiplier.
interface productor_serial_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [WIDTH-1:0]       data0_i;
  logic [WIDTH-1:0]       data1_i;
  logic                   signed_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   overflow_o;

  modport master (
    output in_valid_i, data0_i, data1_i, signed_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, overflow_o
  );

  modport slave (
    input  in_valid_i, data0_i, data1_i, signed_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, overflow_o
  );
endinterface

// File: rtl/productor_serial.sv
// Radix-2 shift-add multiplier, one partial product per clock, valid/ready in and out.
// Define PRODUCTOR_SIGNED_EN to compile in two's-complement operation (signed_i).
module productor_serial #(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  productor_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand, acc, acc_sum, res_fin;
  logic [WIDTH-1:0]     mplier, mag0, mag1;
  logic [CW-1:0]        cnt;
  logic                 ovf_fin;
  logic                 accept, last;

  assign bus.in_ready_o  = (state == IDLE) || (state == DONE && bus.out_ready_i);
  assign bus.out_valid_o = (state == DONE);
  assign accept          = bus.in_valid_i && bus.in_ready_o;
  assign last            = (state == BUSY) && (cnt == CW'(WIDTH-1));

`ifdef PRODUCTOR_SIGNED_EN
  logic neg, neg_in, sgn, sgn_in;

  // Signed operands are reduced to magnitudes; the most-negative value maps
  // to 2^(WIDTH-1), which still fits the unsigned WIDTH-bit register.
  always_comb begin
    mag0   = bus.data0_i;
    mag1   = bus.data1_i;
    neg_in = 1'b0;
    sgn_in = 1'b0;
    if (bus.signed_i) begin
      sgn_in = 1'b1;
      neg_in = bus.data0_i[WIDTH-1] ^ bus.data1_i[WIDTH-1];
      if (bus.data0_i[WIDTH-1]) mag0 = -bus.data0_i;
      if (bus.data1_i[WIDTH-1]) mag1 = -bus.data1_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg <= 1'b0;
      sgn <= 1'b0;
    end else if (accept) begin
      neg <= neg_in;
      sgn <= sgn_in;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = bus.signed_i;
  assign mag0          = bus.data0_i;
  assign mag1          = bus.data1_i;
`endif

  always_comb begin
    acc_sum = acc + (mplier[0] ? mcand : '0);
    res_fin = acc_sum;
    ovf_fin = |acc_sum[2*WIDTH-1:WIDTH];
`ifdef PRODUCTOR_SIGNED_EN
    if (neg) res_fin = -acc_sum;
    // Signed result fits iff the upper half plus the sign bit are all-equal.
    if (sgn) ovf_fin = !((&res_fin[2*WIDTH-1:WIDTH-1]) || !(|res_fin[2*WIDTH-1:WIDTH-1]));
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid_i) state_nxt = BUSY;
      BUSY: if (last)           state_nxt = DONE;
      DONE: if (bus.out_ready_i) state_nxt = bus.in_valid_i ? BUSY : IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      cnt            <= '0;
      bus.result_o   <= '0;
      bus.overflow_o <= 1'b0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, mag0};
      mplier <= mag1;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        bus.result_o   <= res_fin;
        bus.overflow_o <= ovf_fin;
      end
    end
  end
endmodule
